fifo_mem_gen2: RTL and testbench
================================

FIFO_MEM_GEN2 -- requirements
Module: fifo_mem_gen2

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set transaction data width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, SHALL set storage entries; any integer >=2, need not be a power of two.
REQ-003 Parameter AFULL_THRESH, default DEPTH-1, SHALL set the fill level at or above which almost_full_ind asserts (1..DEPTH).
REQ-004 Parameter AEMPTY_THRESH, default 1, SHALL set the fill level at or below which almost_empty_ind asserts (0..DEPTH-1).
REQ-005 Parameter FWFT, default 0, SHALL select read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 Local parameter LVL_W SHALL equal $clog2(DEPTH+1).
REQ-007 clk_in  input  1  single clock; all state on rising edge.
REQ-008 areset_b  input  1  reset, asynchronous assert, active-low.
REQ-009 trans_write  input  1  write request.
REQ-010 trans_read  input  1  read request.
REQ-011 err_clear  input  1  clears sticky overflow/underflow flags.
REQ-012 data_in  input  DATA_WIDTH  write data.
REQ-013 data_out  output  DATA_WIDTH  read data.
REQ-014 data_valid  output  1  data_out holds a valid popped/head word.
REQ-015 fill_level  output  LVL_W  current entry count, 0..DEPTH.
REQ-016 full_ind / empty_ind  output  1 each  fill_level==DEPTH / fill_level==0.
REQ-017 almost_full_ind / almost_empty_ind  output  1 each  threshold flags.
REQ-018 overflow_ind / underflow_ind  output  1 each  sticky error flags.

Function
REQ-019 Read SHALL be accepted when trans_read=1 and empty_ind=0.
REQ-020 Write SHALL be accepted when trans_write=1 and (full_ind=0 or a read is accepted in the same cycle).
REQ-021 Write to empty with simultaneous trans_read SHALL accept the write only; the read is rejected.
REQ-022 Full with simultaneous accepted read and write SHALL keep fill_level at DEPTH and store the new word.
REQ-023 fill_level SHALL update next cycle: +1 write only, -1 read only, unchanged for both or neither.
REQ-024 Write and read pointers SHALL range 0..DEPTH-1 and wrap from DEPTH-1 to 0 on acceptance.
REQ-025 full_ind, empty_ind, almost_full_ind (fill_level>=AFULL_THRESH), almost_empty_ind (fill_level<=AEMPTY_THRESH) SHALL be registered, consistent with fill_level in the same cycle.
REQ-026 FWFT=0: accepted read SHALL drive the popped word on data_out with data_valid=1 exactly one cycle later; data_valid=0 in cycles with no accepted read in the prior cycle; data_out holds its last value.
REQ-027 FWFT=1: data_out SHALL present the head entry and data_valid SHALL equal !empty_ind; trans_read pops the head, next entry visible the following cycle.
REQ-028 FWFT=1: a word written to an empty FIFO SHALL appear on data_out with data_valid=1 one cycle after the write.
REQ-029 overflow_ind SHALL set on trans_write=1 with write rejected; underflow_ind SHALL set on trans_read=1 with read rejected.
REQ-030 Error flags SHALL stay set until err_clear=1; set condition in the same cycle as err_clear SHALL win.
REQ-031 Rejected requests SHALL NOT alter pointers, fill_level or storage contents.

Reset
REQ-032 areset_b=0 SHALL immediately force: pointers 0, fill_level 0, empty_ind 1, almost_empty_ind 1, full_ind 0, almost_full_ind 0, overflow_ind 0, underflow_ind 0, data_valid 0, data_out 0.
REQ-033 Storage array SHALL NOT be reset; contents after reset are unobservable because empty_ind=1.
REQ-034 Reset mid-operation SHALL discard all stored entries; first write after deassertion lands at entry 0.

Verification
REQ-035 DEPTH=5, FWFT=0: write 5 words 0xA0..0xA4 -> full_ind=1 at fill_level 5; read 5 -> data_out 0xA0..0xA4 each one cycle after request, empty_ind=1.
REQ-036 DEPTH=5: 7 write/read rounds of 3 words -> pointers wrap past 4, order preserved, no error flags.
REQ-037 Full FIFO, trans_write=1 alone -> overflow_ind=1, fill_level stays 5; then trans_read+trans_write same cycle -> fill_level 5, new word read last; err_clear=1 -> overflow_ind=0 next cycle.
REQ-038 Empty FIFO, trans_read+trans_write with 0x55 -> underflow_ind=1, fill_level=1; FWFT=1 -> data_out=0x55, data_valid=1 next cycle.
REQ-039 DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2: fill 0->8 -> almost_empty_ind deasserts at level 3, almost_full_ind asserts at level 6.
REQ-040 Assert areset_b=0 at fill_level 4 mid-burst -> all outputs at reset values asynchronously; after release, write 0x11 then read -> data_out 0x11.

Source files
------------

// File: rtl/fifo_mem_gen2.sv
// fifo_mem_gen2: single-clock FIFO with a selectable registered or
// first-word-fall-through read port, fill-level threshold flags and sticky
// overflow/underflow error flags. DEPTH need not be a power of two.
module fifo_mem_gen2 #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = 0,
  localparam int LVL_W        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  trans_write,
  input  logic                  trans_read,
  input  logic                  err_clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [LVL_W-1:0]      fill_level,
  output logic                  full_ind,
  output logic                  empty_ind,
  output logic                  almost_full_ind,
  output logic                  almost_empty_ind,
  output logic                  overflow_ind,
  output logic                  underflow_ind
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_THRESH);
  localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [LVL_W-1:0]      level_next;

  // Accept decisions; a full FIFO can still take a write if a read frees a slot
  // in the same cycle. A read on an empty FIFO is always refused, even when a
  // write arrives alongside it.
  always_comb begin
    rd_accept  = trans_read && !empty_ind;
    wr_accept  = trans_write && (!full_ind || rd_accept);
    level_next = fill_level;
    if (wr_accept && !rd_accept) begin
      level_next = fill_level + 1'b1;
    end else if (rd_accept && !wr_accept) begin
      level_next = fill_level - 1'b1;
    end
  end

  // Pointers, fill level and status flags; flags derive from the next level so
  // they stay consistent with fill_level in every cycle.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fill_level       <= '0;
      full_ind         <= 1'b0;
      empty_ind        <= 1'b1;
      almost_full_ind  <= 1'b0;
      almost_empty_ind <= 1'b1;
    end else begin
      if (wr_accept) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      fill_level       <= level_next;
      full_ind         <= (level_next == LVL_FULL);
      empty_ind        <= (level_next == '0);
      almost_full_ind  <= (level_next >= LVL_AFULL);
      almost_empty_ind <= (level_next <= LVL_AEMPTY);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      overflow_ind  <= 1'b0;
      underflow_ind <= 1'b0;
    end else begin
      if (trans_write && !wr_accept) begin
        overflow_ind <= 1'b1;
      end else if (err_clear) begin
        overflow_ind <= 1'b0;
      end
      if (trans_read && !rd_accept) begin
        underflow_ind <= 1'b1;
      end else if (err_clear) begin
        underflow_ind <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; empty_ind hides stale contents.
  always_ff @(posedge clk_in) begin
    if (wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is shown directly; zero while empty so reset reads as 0.
      assign data_out   = empty_ind ? '0 : mem[rd_ptr];
      assign data_valid = !empty_ind;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      // Registered read: popped word appears one cycle after the accepted read
      // and is held until the next pop.
      always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_accept;
          if (rd_accept) begin
            dout_q <= mem[rd_ptr];
          end
        end
      end

      assign data_out   = dout_q;
      assign data_valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_mem_gen2.sv
// tb_fifo_mem_gen2: drives two FIFO configurations from one stimulus stream
// (DEPTH=5 registered read, DEPTH=8 fall-through with custom thresholds) and
// checks both against queue-based reference models via a negedge monitor.
module tb_fifo_mem_gen2;

  logic       clk_in = 1'b0;
  logic       areset_b = 1'b1;
  logic       trans_write = 1'b0;
  logic       trans_read = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] a_dout;
  logic       a_valid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [2:0] a_lvl;
  logic [7:0] b_dout;
  logic       b_valid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [3:0] b_lvl;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  // Reference models: contents as plain queues, error flags as bits.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] exp_a[$];
  logic [7:0] a_last = '0;
  bit a_ovf_m = 0, a_unf_m = 0, b_ovf_m = 0, b_unf_m = 0;

  fifo_mem_gen2 #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (
    .clk_in(clk_in), .areset_b(areset_b), .trans_write(trans_write),
    .trans_read(trans_read), .err_clear(err_clear), .data_in(data_in),
    .data_out(a_dout), .data_valid(a_valid), .fill_level(a_lvl),
    .full_ind(a_full), .empty_ind(a_empty), .almost_full_ind(a_afull),
    .almost_empty_ind(a_aempty), .overflow_ind(a_ovf), .underflow_ind(a_unf)
  );

  fifo_mem_gen2 #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_THRESH(6),
                  .AEMPTY_THRESH(2), .FWFT(1)) u_b (
    .clk_in(clk_in), .areset_b(areset_b), .trans_write(trans_write),
    .trans_read(trans_read), .err_clear(err_clear), .data_in(data_in),
    .data_out(b_dout), .data_valid(b_valid), .fill_level(b_lvl),
    .full_ind(b_full), .empty_ind(b_empty), .almost_full_ind(b_afull),
    .almost_empty_ind(b_aempty), .overflow_ind(b_ovf), .underflow_ind(b_unf)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference models by one clock using the applied inputs.
  task automatic model_step(input bit wr, input bit rd, input bit clr,
                            input logic [7:0] d);
    bit ra, wa, rb, wb;
    logic [7:0] w;
    ra = rd && (qa.size() != 0);
    wa = wr && ((qa.size() < 5) || ra);
    a_ovf_m = (wr && !wa) ? 1'b1 : (clr ? 1'b0 : a_ovf_m);
    a_unf_m = (rd && !ra) ? 1'b1 : (clr ? 1'b0 : a_unf_m);
    if (ra) begin
      w = qa.pop_front();
      exp_a.push_back(w);
    end
    if (wa) qa.push_back(d);
    rb = rd && (qb.size() != 0);
    wb = wr && ((qb.size() < 8) || rb);
    b_ovf_m = (wr && !wb) ? 1'b1 : (clr ? 1'b0 : b_ovf_m);
    b_unf_m = (rd && !rb) ? 1'b1 : (clr ? 1'b0 : b_unf_m);
    if (rb) void'(qb.pop_front());
    if (wb) qb.push_back(d);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    exp_a.delete();
    a_last = '0;
    a_ovf_m = 0; a_unf_m = 0; b_ovf_m = 0; b_unf_m = 0;
  endtask

  task automatic apply_stimulus(input bit wr, input bit rd, input bit clr,
                                input logic [7:0] d);
    trans_write = wr;
    trans_read  = rd;
    err_clear   = clr;
    data_in     = d;
    @(posedge clk_in);
    model_step(wr, rd, clr, d);
    @(negedge clk_in);
    #1;
  endtask

  task automatic check_reset_values();
    check_output("a_rst_lvl", a_lvl, 0);
    check_output("a_rst_empty", a_empty, 1);
    check_output("a_rst_aempty", a_aempty, 1);
    check_output("a_rst_full", a_full, 0);
    check_output("a_rst_afull", a_afull, 0);
    check_output("a_rst_ovf", a_ovf, 0);
    check_output("a_rst_unf", a_unf, 0);
    check_output("a_rst_valid", a_valid, 0);
    check_output("a_rst_dout", a_dout, 0);
    check_output("b_rst_lvl", b_lvl, 0);
    check_output("b_rst_empty", b_empty, 1);
    check_output("b_rst_aempty", b_aempty, 1);
    check_output("b_rst_full", b_full, 0);
    check_output("b_rst_afull", b_afull, 0);
    check_output("b_rst_ovf", b_ovf, 0);
    check_output("b_rst_unf", b_unf, 0);
    check_output("b_rst_valid", b_valid, 0);
    check_output("b_rst_dout", b_dout, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++)
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  // Monitor: pops the scoreboard whenever the registered port presents data
  // and compares every status output against the models.
  always @(negedge clk_in) begin
    logic [7:0] w;
    if (mon_en && areset_b) begin
      check_output("a_valid", a_valid, exp_a.size() != 0);
      if (exp_a.size() != 0) begin
        w = exp_a.pop_front();
        a_last = w;
      end
      check_output("a_data", a_dout, a_last);
      check_output("a_lvl", a_lvl, qa.size());
      check_output("a_full", a_full, qa.size() == 5);
      check_output("a_empty", a_empty, qa.size() == 0);
      check_output("a_afull", a_afull, qa.size() >= 4);
      check_output("a_aempty", a_aempty, qa.size() <= 1);
      check_output("a_ovf", a_ovf, a_ovf_m);
      check_output("a_unf", a_unf, a_unf_m);
      check_output("b_valid", b_valid, qb.size() != 0);
      if (qb.size() != 0) check_output("b_data", b_dout, qb[0]);
      check_output("b_lvl", b_lvl, qb.size());
      check_output("b_full", b_full, qb.size() == 8);
      check_output("b_empty", b_empty, qb.size() == 0);
      check_output("b_afull", b_afull, qb.size() >= 6);
      check_output("b_aempty", b_aempty, qb.size() <= 2);
      check_output("b_ovf", b_ovf, b_ovf_m);
      check_output("b_unf", b_unf, b_unf_m);
    end
  end

  // Directed scenarios followed by biased random traffic and a mid-burst reset.
  initial begin
    #1 areset_b = 1'b0;
    #2 check_reset_values();
    @(posedge clk_in);
    @(negedge clk_in);
    #1 areset_b = 1'b1;
    mon_en = 1'b1;

    $display("[TB] fill and drain DEPTH=5");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);

    $display("[TB] overflow and simultaneous read/write when full");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'hCC);
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'hEE);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    drain();
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);

    $display("[TB] read+write on empty");
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h55);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    drain();
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);

    $display("[TB] pointer wrap rounds");
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'(r * 16 + i));
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    end

    $display("[TB] threshold sweep DEPTH=8");
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
    drain();
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      apply_stimulus($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp,
                     $urandom_range(0, 15) == 0, 8'($urandom));
    end

    $display("[TB] mid-burst reset");
    drain();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
    trans_write = 1'b0;
    trans_read  = 1'b0;
    err_clear   = 1'b0;
    areset_b = 1'b0;
    model_reset();
    #1 check_reset_values();
    @(posedge clk_in);
    @(negedge clk_in);
    #1 areset_b = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h11);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
